model_trainer_differentiation_scheduler: RTL and testbench
==========================================================

# model_trainer_differentiation_scheduler

Sequencing controller for the trainer's differentiation step. It streams a SIZE_T_IN × SIZE_L_IN matrix of samples in row-major order (time-major), one element per handshake. For each element it emits the first-order temporal difference x[t][l] − x[t−1][l], with x[−1][l] = 0, so that t = 0 returns the sample itself. A row buffer of depth L holds the previous time step. Division by the step length is performed by the downstream scaler, not by this block.

## Interface
Parameters:
- DATA_SIZE, 64, width of data, sizes and indices
- CONTROL_SIZE, 4, width of the FSM state register
- L, 64, maximum row length; depth of the previous-row buffer

Ports:
- CLK  in  1  clock; all logic is on the rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  begin an operation; sampled only in IDLE
- READY  out  1  one-cycle pulse when the operation completes
- SIZE_T_IN  in  DATA_SIZE  number of time steps; latched at START
- SIZE_L_IN  in  DATA_SIZE  row length; latched at START; clamped to L when larger
- DATA_ENABLE  out  1  block can accept an element
- DATA_IN_ENABLE  in  1  DATA_IN valid
- DATA_IN  in  DATA_SIZE  sample x[t][l], two's complement
- DATA_OUT_ENABLE  out  1  DATA_OUT valid; one-cycle pulse
- DATA_OUT  out  DATA_SIZE  difference result
- INDEX_T_OUT  out  DATA_SIZE  t of the current DATA_OUT
- INDEX_L_OUT  out  DATA_SIZE  l of the current DATA_OUT

## Operation
- **FSM states:** IDLE, INPUT, COMPUTE, ENDER.
- **IDLE:**
  - On START=1, latch sizes and clear the t and l counters.
  - If either latched size is 0, go to ENDER.
  - Otherwise go to INPUT.
  - START in any other state is ignored.
- **INPUT:**
  - DATA_ENABLE=1.
  - An element is accepted on an edge where DATA_IN_ENABLE=1.
  - On acceptance:
    - DATA_OUT ← DATA_IN − (t==0 ? 0 : buf[l]).
    - buf[l] ← DATA_IN.
    - INDEX_T_OUT ← t and INDEX_L_OUT ← l.
    - DATA_OUT_ENABLE ← 1.
    - Go to COMPUTE.
  - With no valid input, remain in INPUT indefinitely.
- **COMPUTE:**
  - DATA_ENABLE=0; DATA_OUT_ENABLE drops to 0 on the leaving edge.
  - Advance l. If l == SIZE_L−1, then l←0 and t←t+1.
  - If the element just processed was (SIZE_T−1, SIZE_L−1), go to ENDER; otherwise go to INPUT.
- **ENDER:** READY=1 for exactly one cycle, then go to IDLE.
- **Arithmetic:** subtraction is modulo 2^DATA_SIZE with no saturation and no overflow flag.
- **Buffer:** buf is not cleared by reset or START. Row t=0 never reads it, so stale contents are harmless.
- **Reset:** RST=1 on any edge returns the FSM to IDLE regardless of state. It zeroes the counters, latched sizes and all outputs (READY, DATA_ENABLE, DATA_OUT_ENABLE, DATA_OUT, INDEX_T_OUT, INDEX_L_OUT = 0). An aborted operation produces no READY.

## Timing
- **Start latency:** START sampled at edge e0 → DATA_ENABLE=1 in the cycle after e0.
- **Output latency:** element accepted at edge k → DATA_OUT_ENABLE=1 with valid DATA_OUT and indices during cycle k+1.
- **Throughput:** at most one element per 2 cycles; DATA_ENABLE is low in the cycle after each acceptance.
- **Completion:** last element accepted at edge k → READY=1 during cycle k+2.
- **Zero size:** START at e0 → READY=1 in the cycle after e0; no DATA_OUT_ENABLE pulse occurs.
- **Output hold:** DATA_OUT and the indices hold their last values until the next acceptance or reset.
- **Start priority:** START and RST asserted on the same edge → RST wins.

## Test plan
- **Reset values:** assert RST for 2 cycles → every output is 0 and the FSM is in IDLE (DATA_ENABLE=0).
- **Nominal 3×2:** SIZE_T=3, SIZE_L=2, inputs 5,7,8,4,8,10.
  - DATA_OUT sequence: 5, 7, 3, 2^64−3, 0, 6.
  - Index pairs: (0,0), (0,1), (1,0), (1,1), (2,0), (2,1).
  - One READY pulse, 2 cycles after the last acceptance.
- **Zero size:** SIZE_T=0, SIZE_L=4, START → READY the next cycle, no output pulse. Repeat with SIZE_L=0; same result.
- **Stall and ignored START:** after the first acceptance, hold DATA_IN_ENABLE low for 10 cycles and pulse START in between.
  - DATA_ENABLE stays 1 and no DATA_OUT_ENABLE occurs.
  - Sizes and counters are unchanged; the operation completes normally afterwards.
- **Wrap-around:** SIZE_T=2, SIZE_L=1, inputs 0x8000_0000_0000_0000 then 0x7FFF_FFFF_FFFF_FFFF → outputs 0x8000_0000_0000_0000 then 0xFFFF_FFFF_FFFF_FFFF.
- **Reset mid-operation and clamp:**
  - Assert RST after 3 of 6 elements → no READY is produced.
  - Restart with SIZE_T=2, SIZE_L=2 → row 0 outputs equal its inputs (no stale buffer use).
  - SIZE_L_IN=L+5 → rows wrap at l=L−1.

Source files
------------

// File: rtl/model_trainer_differentiation_scheduler.sv
// First-order temporal difference sequencer.
// Streams a T x L sample matrix in row-major order and emits
// x[t][l] - x[t-1][l] per element, with row 0 passed through unchanged.
module model_trainer_differentiation_scheduler #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 4,
  parameter int unsigned L            = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_T_IN,
  input  logic [DATA_SIZE-1:0] SIZE_L_IN,
  output logic                 DATA_ENABLE,
  input  logic                 DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic                 DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic [DATA_SIZE-1:0] INDEX_T_OUT,
  output logic [DATA_SIZE-1:0] INDEX_L_OUT
);

  localparam int unsigned AW = (L > 1) ? $clog2(L) : 1;

  localparam logic [CONTROL_SIZE-1:0] ST_IDLE    = CONTROL_SIZE'(0);
  localparam logic [CONTROL_SIZE-1:0] ST_INPUT   = CONTROL_SIZE'(1);
  localparam logic [CONTROL_SIZE-1:0] ST_COMPUTE = CONTROL_SIZE'(2);
  localparam logic [CONTROL_SIZE-1:0] ST_ENDER   = CONTROL_SIZE'(3);

  logic [CONTROL_SIZE-1:0] state_q, state_d;
  logic [DATA_SIZE-1:0]    size_t_q, size_t_d;
  logic [DATA_SIZE-1:0]    size_l_q, size_l_d;
  logic [DATA_SIZE-1:0]    t_q, t_d;
  logic [DATA_SIZE-1:0]    l_q, l_d;
  logic [DATA_SIZE-1:0]    data_out_q, data_out_d;
  logic [DATA_SIZE-1:0]    idx_t_q, idx_t_d;
  logic [DATA_SIZE-1:0]    idx_l_q, idx_l_d;
  logic                    dout_en_q, dout_en_d;
  logic                    ready_q, ready_d;
  logic                    data_en_q, data_en_d;
  logic                    accept;

  logic [DATA_SIZE-1:0]    row_buf_q [L];
  logic [AW-1:0]           buf_idx_c;
  logic [DATA_SIZE-1:0]    prev_c;
  logic [DATA_SIZE-1:0]    size_l_clamp_c;

  // Row length saturates at the buffer depth; l never exceeds L-1
  assign size_l_clamp_c = (SIZE_L_IN > DATA_SIZE'(L)) ? DATA_SIZE'(L) : SIZE_L_IN;
  assign buf_idx_c      = l_q[AW-1:0];
  // Row 0 subtracts zero, so stale buffer contents are never observed
  assign prev_c         = (t_q == '0) ? '0 : row_buf_q[buf_idx_c];

  // Next-state, counter and output logic
  always_comb begin
    state_d    = state_q;
    size_t_d   = size_t_q;
    size_l_d   = size_l_q;
    t_d        = t_q;
    l_d        = l_q;
    data_out_d = data_out_q;
    idx_t_d    = idx_t_q;
    idx_l_d    = idx_l_q;
    dout_en_d  = 1'b0;
    accept     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          size_t_d = SIZE_T_IN;
          size_l_d = size_l_clamp_c;
          t_d      = '0;
          l_d      = '0;
          if ((SIZE_T_IN == '0) || (size_l_clamp_c == '0)) state_d = ST_ENDER;
          else                                              state_d = ST_INPUT;
        end
      end
      ST_INPUT: begin
        if (DATA_IN_ENABLE) begin
          accept     = 1'b1;
          data_out_d = DATA_IN - prev_c;
          idx_t_d    = t_q;
          idx_l_d    = l_q;
          dout_en_d  = 1'b1;
          state_d    = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (l_q == size_l_q - DATA_SIZE'(1)) begin
          l_d = '0;
          t_d = t_q + DATA_SIZE'(1);
        end else begin
          l_d = l_q + DATA_SIZE'(1);
        end
        if ((t_q == size_t_q - DATA_SIZE'(1)) && (l_q == size_l_q - DATA_SIZE'(1)))
          state_d = ST_ENDER;
        else
          state_d = ST_INPUT;
      end
      ST_ENDER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d   = (state_d == ST_ENDER);
    data_en_d = (state_d == ST_INPUT);
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      size_t_q   <= '0;
      size_l_q   <= '0;
      t_q        <= '0;
      l_q        <= '0;
      data_out_q <= '0;
      idx_t_q    <= '0;
      idx_l_q    <= '0;
      dout_en_q  <= 1'b0;
      ready_q    <= 1'b0;
      data_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_t_q   <= size_t_d;
      size_l_q   <= size_l_d;
      t_q        <= t_d;
      l_q        <= l_d;
      data_out_q <= data_out_d;
      idx_t_q    <= idx_t_d;
      idx_l_q    <= idx_l_d;
      dout_en_q  <= dout_en_d;
      ready_q    <= ready_d;
      data_en_q  <= data_en_d;
    end
  end

  // Previous-row buffer; deliberately not cleared
  always_ff @(posedge CLK) begin
    if (!RST && accept) row_buf_q[buf_idx_c] <= DATA_IN;
  end

  assign READY           = ready_q;
  assign DATA_ENABLE     = data_en_q;
  assign DATA_OUT_ENABLE = dout_en_q;
  assign DATA_OUT        = data_out_q;
  assign INDEX_T_OUT     = idx_t_q;
  assign INDEX_L_OUT     = idx_l_q;

endmodule

// File: tb/tb_model_trainer_differentiation_scheduler.sv
// Directed bench for the differentiation scheduler.
module tb_model_trainer_differentiation_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        READY;
  logic [63:0] SIZE_T_IN = '0;
  logic [63:0] SIZE_L_IN = '0;
  logic        DATA_ENABLE;
  logic        DATA_IN_ENABLE = 1'b0;
  logic [63:0] DATA_IN = '0;
  logic        DATA_OUT_ENABLE;
  logic [63:0] DATA_OUT;
  logic [63:0] INDEX_T_OUT;
  logic [63:0] INDEX_L_OUT;

  int n_cmp = 0;
  int n_err = 0;
  int ready_cnt = 0;
  int dout_cnt = 0;

  model_trainer_differentiation_scheduler #(
    .DATA_SIZE(64), .CONTROL_SIZE(4), .L(64)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .SIZE_T_IN(SIZE_T_IN), .SIZE_L_IN(SIZE_L_IN),
    .DATA_ENABLE(DATA_ENABLE), .DATA_IN_ENABLE(DATA_IN_ENABLE), .DATA_IN(DATA_IN),
    .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .DATA_OUT(DATA_OUT),
    .INDEX_T_OUT(INDEX_T_OUT), .INDEX_L_OUT(INDEX_L_OUT)
  );

  always #5 CLK = ~CLK;

  // Pulse counters, sampled mid-cycle
  always @(negedge CLK) begin
    if (READY === 1'b1) ready_cnt++;
    if (DATA_OUT_ENABLE === 1'b1) dout_cnt++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [63:0] st, input logic [63:0] sl);
    SIZE_T_IN = st;
    SIZE_L_IN = sl;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Wait (bounded) for DATA_ENABLE, present one element, check the result
  task automatic send(input logic [63:0] v, input logic [63:0] exp_d,
                      input logic [63:0] et, input logic [63:0] el);
    int w;
    w = 0;
    while (DATA_ENABLE !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk1("data_enable_wait", DATA_ENABLE, 1'b1);
    DATA_IN = v;
    DATA_IN_ENABLE = 1'b1;
    tick();
    DATA_IN_ENABLE = 1'b0;
    chk1("dout_en", DATA_OUT_ENABLE, 1'b1);
    chk("dout", DATA_OUT, exp_d);
    chk("idx_t", INDEX_T_OUT, et);
    chk("idx_l", INDEX_L_OUT, el);
    chk1("de_low_after_accept", DATA_ENABLE, 1'b0);
  endtask

  // Called in the cycle right after the last acceptance
  task automatic finish_op();
    int r0;
    r0 = ready_cnt;
    tick();
    chk1("ready_pulse", READY, 1'b1);
    tick();
    chk1("ready_drop", READY, 1'b0);
    chk1("idle_de", DATA_ENABLE, 1'b0);
    chk("ready_count", 64'(ready_cnt), 64'(r0 + 1));
  endtask

  initial begin
    int d0;
    int r0;

    // Reset values, with START colliding on a reset edge
    START = 1'b1;
    SIZE_T_IN = 64'd3;
    SIZE_L_IN = 64'd2;
    tick();
    START = 1'b0;
    tick();
    chk1("rst_ready", READY, 1'b0);
    chk1("rst_de", DATA_ENABLE, 1'b0);
    chk1("rst_dout_en", DATA_OUT_ENABLE, 1'b0);
    chk("rst_dout", DATA_OUT, 64'd0);
    chk("rst_idx_t", INDEX_T_OUT, 64'd0);
    chk("rst_idx_l", INDEX_L_OUT, 64'd0);
    RST = 1'b0;
    tick();
    chk1("idle_after_rst", DATA_ENABLE, 1'b0);

    // Nominal 3x2
    start_op(64'd3, 64'd2);
    chk1("start_latency", DATA_ENABLE, 1'b1);
    send(64'd5,  64'd5, 64'd0, 64'd0);
    send(64'd7,  64'd7, 64'd0, 64'd1);
    send(64'd8,  64'd3, 64'd1, 64'd0);
    send(64'd4,  64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 64'd1);
    send(64'd8,  64'd0, 64'd2, 64'd0);
    send(64'd10, 64'd6, 64'd2, 64'd1);
    finish_op();
    chk("hold_dout", DATA_OUT, 64'd6);
    chk("hold_idx_t", INDEX_T_OUT, 64'd2);

    // Zero size: T=0, then L=0
    d0 = dout_cnt;
    start_op(64'd0, 64'd4);
    chk1("zero_t_ready", READY, 1'b1);
    chk1("zero_t_de", DATA_ENABLE, 1'b0);
    tick();
    chk1("zero_t_ready_drop", READY, 1'b0);
    start_op(64'd4, 64'd0);
    chk1("zero_l_ready", READY, 1'b1);
    tick();
    chk1("zero_l_ready_drop", READY, 1'b0);
    tick();
    chk("zero_no_dout", 64'(dout_cnt), 64'(d0));

    // Stall with an ignored START
    start_op(64'd2, 64'd2);
    send(64'd1, 64'd1, 64'd0, 64'd0);
    tick();
    d0 = dout_cnt;
    for (int i = 0; i < 10; i++) begin
      chk1("stall_de", DATA_ENABLE, 1'b1);
      if (i == 4) begin
        SIZE_T_IN = 64'd7;
        SIZE_L_IN = 64'd7;
        START = 1'b1;
      end
      tick();
      START = 1'b0;
    end
    chk("stall_no_dout", 64'(dout_cnt), 64'(d0));
    send(64'd2, 64'd2, 64'd0, 64'd1);
    send(64'd3, 64'd2, 64'd1, 64'd0);
    send(64'd4, 64'd2, 64'd1, 64'd1);
    finish_op();

    // Modular wrap-around
    start_op(64'd2, 64'd1);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'd0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    finish_op();

    // Reset mid-operation: no READY afterwards
    start_op(64'd2, 64'd3);
    send(64'd9, 64'd9, 64'd0, 64'd0);
    send(64'd9, 64'd9, 64'd0, 64'd1);
    send(64'd9, 64'd9, 64'd0, 64'd2);
    r0 = ready_cnt;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk1("midrst_dout_en", DATA_OUT_ENABLE, 1'b0);
    chk("midrst_dout", DATA_OUT, 64'd0);
    chk("midrst_idx_l", INDEX_L_OUT, 64'd0);
    for (int i = 0; i < 5; i++) tick();
    chk1("midrst_idle", DATA_ENABLE, 1'b0);
    chk("midrst_no_ready", 64'(ready_cnt), 64'(r0));

    // Restart: row 0 must pass through despite stale buffer
    start_op(64'd2, 64'd2);
    send(64'd11, 64'd11, 64'd0, 64'd0);
    send(64'd12, 64'd12, 64'd0, 64'd1);
    send(64'd13, 64'd2,  64'd1, 64'd0);
    send(64'd20, 64'd8,  64'd1, 64'd1);
    finish_op();

    // Row length clamp: L+5 requested, rows wrap after l=63
    start_op(64'd2, 64'd69);
    for (int i = 0; i < 64; i++) send(64'(i * 3), 64'(i * 3), 64'd0, 64'(i));
    for (int i = 0; i < 64; i++) send(64'(i * 5), 64'(i * 2), 64'd1, 64'(i));
    finish_op();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
